// File: rtl/req_pend_pkg.sv
// Shared definitions for the request pending collector.
//   state_t    : hold-off FSM states (idle, active service, blanked hold-off)
//   HOLD_CNT_W : width of the hold-off down-counter (HOLDOFF range 1..15)
//   idx_w()    : index width needed to address n channels
package req_pend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int HOLD_CNT_W = 4;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_edge_detect.sv
// Request event detector: registers the raw request lines once and turns
// them into per-channel event strobes.
//   clk, rst : clock, asynchronous active-high reset
//   req_in   : raw request lines (synchronous to clk)
//   evt      : event strobe per channel (rising edge or level, per EDGE_MODE)
module req_edge_detect #(
  parameter int N         = 4,
  parameter int EDGE_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] evt
);

  logic [N-1:0] req_q;

  // req_q resets to 0, so a line already high when reset drops counts as an
  // edge in the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_in;
  end

  assign evt = (EDGE_MODE != 0) ? (req_in & ~req_q) : req_in;

endmodule

// File: rtl/req_pending_collector.sv
// Front end of the 4-bit priority decoder. Request events become sticky
// pending bits; pending & mask drives the decoder's din. The decoder index
// comes back as a clear command, after which din is blanked for HOLDOFF
// cycles so the registered decoder output can settle. A second event on a
// still-pending channel raises a sticky overflow flag.
// Optional build macro: PEND_COUNT_EN adds per-channel saturating coalesce
// counters and the cnt_flat output.
//   clk, rst  : clock, asynchronous active-high reset
//   req_in    : raw request lines
//   mask      : 1 = channel visible to the decoder
//   clr_valid : clear strobe, clr_idx selects the channel (out of range ignored)
//   ovf_clr   : clears all overflow flags
//   din_out   : pending & mask, forced to 0 during hold-off
//   any_pend  : |(pending & mask), not affected by hold-off
//   busy      : FSM not idle
//   ovf       : sticky per-channel overflow flags
//   cnt_flat  : per-channel coalesce counts, ch0 in LSBs (PEND_COUNT_EN only)
module req_pending_collector
  import req_pend_pkg::*;
#(
  parameter int N         = 4,
  parameter int IDXW      = idx_w(N),
  parameter int EDGE_MODE = 1,
  parameter int HOLDOFF   = 2,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  input  logic [N-1:0]      mask,
  input  logic              clr_valid,
  input  logic [IDXW-1:0]   clr_idx,
  input  logic              ovf_clr,
  output logic [N-1:0]      din_out,
  output logic              any_pend,
  output logic              busy,
`ifdef PEND_COUNT_EN
  output logic [N*CNT_W-1:0] cnt_flat,
`endif
  output logic [N-1:0]      ovf
);

  state_t                state;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [N-1:0]          evt;
  logic [N-1:0]          pend;
  logic [N-1:0]          ovf_r;
  logic [N-1:0]          clr_hit;
  logic [N-1:0]          qual;
  logic [N-1:0]          masked;
  logic                  clr_any;

  req_edge_detect #(.N(N), .EDGE_MODE(EDGE_MODE)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .req_in (req_in),
    .evt    (evt)
  );

  // One-hot clear decode; an index >= N matches no bit and is dropped.
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < N; i++) clr_hit[i] = clr_valid && (int'(clr_idx) == i);
  end

  assign clr_any  = |clr_hit;
  // Event on a bit that is pending and not being cleared right now.
  assign qual     = evt & pend & ~clr_hit;
  assign masked   = pend & mask;
  assign any_pend = |masked;
  assign din_out  = (state == ST_HOLD) ? '0 : masked;
  assign busy     = (state != ST_IDLE);
  assign ovf      = ovf_r;

  // Set has priority over clear so a same-cycle event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      ovf_r <= '0;
    end else begin
      pend  <= (pend & ~clr_hit) | evt;
      ovf_r <= ovf_clr ? '0 : (ovf_r | qual);
    end
  end

  // Hold-off FSM. A clear while already in HOLD does not restart the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_pend) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (clr_any) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_CNT_W'(HOLDOFF - 1);
          end else if (!any_pend) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state <= any_pend ? ST_ACTIVE : ST_IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PEND_COUNT_EN
  logic [CNT_W-1:0] cnt [N];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Any clear of the channel zeroes its count, including the set-wins case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_hit[i])   cnt[i] <= '0;
        else if (qual[i]) cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < N; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule
